scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count (power of two, >=2).
REQ-003 SHALL have parameter NRD, default 2, meaning read port count (1..4).
REQ-004 SHALL have parameter MAXPEND, default 3, meaning maximum in-flight writes per register (1..7).
REQ-005 SHALL have parameter ZERO_R0, default 1, meaning register 0 reads 0, never busy, and ignores writes/issues.
REQ-006 SHALL derive AW = clog2(NREGS) and CW = clog2(MAXPEND+1).
REQ-007 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-009 SHALL have port rd_valid, input, NRD, per-port read request.
REQ-010 SHALL have port rd_addr, input, NRD*AW, packed read addresses (port k at [k*AW +: AW]).
REQ-011 SHALL have port rd_data, output, NRD*XLEN, packed read data.
REQ-012 SHALL have port rd_busy, output, NRD, per-port "value not yet available".
REQ-013 SHALL have port wb_en, input, 1, writeback strobe.
REQ-014 SHALL have port wb_addr, input, AW, writeback register.
REQ-015 SHALL have port wb_data, input, XLEN, writeback value.
REQ-016 SHALL have port iss_valid, input, 1, decode stage requests issue of an instruction.
REQ-017 SHALL have port iss_we, input, 1, issuing instruction writes a register.
REQ-018 SHALL have port iss_rd, input, AW, issuing instruction destination.
REQ-019 SHALL have port stall, output, 1, issue blocked this cycle.
REQ-020 SHALL have port iss_fire, output, 1, issue accepted this cycle (iss_valid & ~stall).

Function
REQ-021 SHALL provide combinational reads; rd_data = wb_data when wb_en & wb_addr==rd_addr (write-through bypass), else stored value.
REQ-022 SHALL write wb_data into register wb_addr on the clock edge when wb_en.
REQ-023 SHALL keep a CW-bit pending counter per register; busy(r) = pend(r)!=0.
REQ-024 SHALL increment pend(iss_rd) when iss_fire & iss_we; decrement pend(wb_addr) when wb_en.
REQ-025 SHALL leave pend unchanged when increment and decrement hit the same register in one cycle.
REQ-026 SHALL ignore wb_en decrement on a register whose pend is 0 (no underflow); data write still occurs.
REQ-027 SHALL compute rd_busy[k] = rd_valid[k] & (pend(addr)>1 | (pend(addr)==1 & ~(wb_en & wb_addr==addr))).
REQ-028 SHALL assert stall = iss_valid & (|rd_busy | (iss_we & pend(iss_rd)==MAXPEND & ~(wb_en & wb_addr==iss_rd))).
REQ-029 SHALL treat register 0 (ZERO_R0=1) as rd_data=0, rd_busy=0, never counted, never written.
REQ-030 SHALL have zero-cycle latency for all outputs (purely combinational from inputs and state).
REQ-031 SHALL not alter any counter when stall is high, regardless of iss_we.

Reset
REQ-032 SHALL clear every data register and every pend counter to 0 asynchronously while rst is low.
REQ-033 SHALL drive rd_busy=0, stall=0, iss_fire=0 during reset; rd_data=0; writes during reset discarded.
REQ-034 SHALL resume on the first rising clk after rst deasserts; in-flight writes before reset are forgotten.

Structure
REQ-035 SHALL place the port-slicing width functions and the pend-counter width constant in the shared processor package.
REQ-036 SHALL instantiate one sub-module, pend_counter (saturating up/down counter with inc, dec, zero, full), per register.
REQ-037 SHALL be a drop-in successor to the single-write two-read register file used by the pipelined datapath.

Verification
REQ-038 SHALL cover bypass: write r5=0xDEADBEEF with rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF that cycle, rd_busy0=0.
REQ-039 SHALL cover RAW stall: issue we r3, next cycle read r3 -> stall=1 until wb r3 cycle, where stall=0 and data bypassed.
REQ-040 SHALL cover WAW: issue r7 twice, one wb r7 -> pend=1, rd_busy stays 1; second wb -> busy 0.
REQ-041 SHALL cover saturation: MAXPEND=3, three issues to r9, fourth -> stall=1; with simultaneous wb r9 -> iss_fire=1, pend stays 3.
REQ-042 SHALL cover r0: issue/write r0=0x1234 -> rd_data=0, rd_busy=0, no stall.
REQ-043 SHALL cover reset mid-operation: pend r4=2, assert rst -> rd_busy=0, rd_data(r4)=0 immediately, before any clk edge.

Source files
------------

// File: rtl/scoreboard_regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   addr_width  : register-index width for a given register count
//   pend_width  : pending-counter width for a given in-flight limit
//   slice_lo    : low bit of port k inside a packed multi-port bus
//   PEND_CW     : pending-counter width for the default in-flight limit
//   pend_op_e   : per-cycle action applied to a pending counter
package scoreboard_regfile_pkg;

    localparam int unsigned PEND_MAXPEND_DFLT = 3;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    function automatic int unsigned pend_width(input int unsigned maxpend);
        return $clog2(maxpend + 1);
    endfunction

    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    localparam int unsigned PEND_CW = pend_width(PEND_MAXPEND_DFLT);

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_DEC  = 2'b10
    } pend_op_e;

endpackage

// File: rtl/scoreboard_regfile_pend.sv
// Saturating up/down counter tracking the in-flight writes to one register.
//   clk, rst   : clock, asynchronous active-low reset
//   inc, dec   : issue of a writer / writeback of a writer
//   cnt        : current number of in-flight writes
//   zero, full : cnt == 0 / cnt == MAXPEND
module pend_counter
    import scoreboard_regfile_pkg::*;
#(
    parameter int unsigned MAXPEND = PEND_MAXPEND_DFLT,
    parameter int unsigned CW      = PEND_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero,
    output logic          full
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    pend_op_e      op;

    assign zero = (cnt_q == '0);
    assign full = (cnt_q == CW'(MAXPEND));
    assign cnt  = cnt_q;

    // A simultaneous issue and writeback cancel out, even at zero.
    always_comb begin
        op = PC_HOLD;
        if (inc && !dec && !full) begin
            op = PC_INC;
        end else if (dec && !inc && !zero) begin
            op = PC_DEC;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            PC_INC:  cnt_d = cnt_q + 1'b1;
            PC_DEC:  cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard.
//   clk, rst              : clock, asynchronous active-low reset
//   rd_valid/rd_addr      : NRD read requests, packed addresses
//   rd_data/rd_busy       : packed read data, per-port "value not ready"
//   wb_en/wb_addr/wb_data : single writeback port (bypassed to reads)
//   iss_valid/iss_we/iss_rd : instruction issue request and destination
//   stall/iss_fire        : issue blocked / issue accepted this cycle
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned MAXPEND = 3,
    parameter bit          ZERO_R0 = 1'b1,
    localparam int unsigned AW     = addr_width(NREGS),
    localparam int unsigned CW     = pend_width(MAXPEND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_valid,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_valid,
    input  logic                iss_we,
    input  logic [AW-1:0]       iss_rd,
    output logic                stall,
    output logic                iss_fire
);

    logic [XLEN-1:0]  mem_d [NREGS];
    logic [XLEN-1:0]  mem_q [NREGS];
    logic [CW-1:0]    pend  [NREGS];
    logic [NREGS-1:0] pend_inc;
    logic [NREGS-1:0] pend_dec;
    logic [NREGS-1:0] pend_zero;
    logic [NREGS-1:0] pend_full;
    logic             wb_hit_iss;

    // Scoreboard: one counter per register; a hard-wired r0 never counts.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam bit HARD_ZERO = ZERO_R0 && (r == 0);

        assign pend_inc[r] = !HARD_ZERO && iss_fire && iss_we && (iss_rd == AW'(r));
        assign pend_dec[r] = !HARD_ZERO && wb_en && (wb_addr == AW'(r));

        pend_counter #(
            .MAXPEND (MAXPEND),
            .CW      (CW)
        ) u_pend (
            .clk  (clk),
            .rst  (rst),
            .inc  (pend_inc[r]),
            .dec  (pend_dec[r]),
            .cnt  (pend[r]),
            .zero (pend_zero[r]),
            .full (pend_full[r])
        );
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        if (wb_en && !(ZERO_R0 && (wb_addr == '0))) begin
            mem_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Read ports. A register with exactly one writer outstanding is ready
    // in the cycle that writer retires, since the value is bypassed.
    // Outputs are forced quiet while reset is held, independent of inputs.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rd_a;
        logic          rd_r0;
        logic          wb_hit;

        assign rd_a   = rd_addr[slice_lo(k, AW) +: AW];
        assign rd_r0  = ZERO_R0 && (rd_a == '0);
        assign wb_hit = wb_en && (wb_addr == rd_a);

        assign rd_data[slice_lo(k, XLEN) +: XLEN] =
            (!rst || rd_r0) ? '0 : (wb_hit ? wb_data : mem_q[rd_a]);

        assign rd_busy[k] = rst && rd_valid[k] && !rd_r0 && !pend_zero[rd_a]
                            && ((pend[rd_a] != CW'(1)) || !wb_hit);
    end

    // A full destination may still accept a new writer when one retires
    // in the same cycle; the counter then holds at MAXPEND.
    assign wb_hit_iss = wb_en && (wb_addr == iss_rd);
    assign stall      = rst && iss_valid
                        && ((|rd_busy) || (iss_we && pend_full[iss_rd] && !wb_hit_iss));
    assign iss_fire   = rst && iss_valid && !stall;

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD-1:0]      rd_valid;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_valid;
    logic                iss_we;
    logic [AW-1:0]       iss_rd;
    logic                stall;
    logic                iss_fire;

    int n_checks = 0;
    int n_errors = 0;

    scoreboard_regfile #(
        .XLEN    (32),
        .NREGS   (32),
        .NRD     (2),
        .MAXPEND (3),
        .ZERO_R0 (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .stall     (stall),
        .iss_fire  (iss_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_valid  = '0;
        rd_addr   = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        iss_valid = 1'b0;
        iss_we    = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        rd_valid[k]         = 1'b1;
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic iss(input logic [AW-1:0] a, input logic we);
        iss_valid = 1'b1;
        iss_we    = we;
        iss_rd    = a;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held, with activity on every input.
        rst = 1'b0;
        idle();
        wb(5'd5, 32'hAAAA_AAAA);
        rd(0, 5'd5);
        iss(5'd5, 1'b1);
        #2;
        chk("rst_rd_data0", rd_data[31:0], 32'h0);
        chk("rst_rd_busy", {30'b0, rd_busy}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_iss_fire", {31'b0, iss_fire}, 32'h0);
        step();
        step();
        rst = 1'b1;
        idle();
        rd(0, 5'd5);
        settle();
        chk("rst_write_discarded", rd_data[31:0], 32'h0);
        chk("rst_issue_discarded", {30'b0, rd_busy}, 32'h0);

        // Bypass.
        step();
        idle();
        wb(5'd5, 32'hDEAD_BEEF);
        rd(0, 5'd5);
        settle();
        chk("bypass_data", rd_data[31:0], 32'hDEAD_BEEF);
        chk("bypass_busy", {31'b0, rd_busy[0]}, 32'h0);
        step();
        idle();
        rd(1, 5'd5);
        settle();
        chk("stored_r5_port1", rd_data[63:32], 32'hDEAD_BEEF);
        chk("stored_r5_busy", {31'b0, rd_busy[1]}, 32'h0);

        // RAW stall on r3; stalled issues to r10 must not count.
        step();
        idle();
        iss(5'd3, 1'b1);
        settle();
        chk("raw_issue_fire", {31'b0, iss_fire}, 32'h1);
        chk("raw_issue_stall", {31'b0, stall}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            idle();
            iss(5'd10, 1'b1);
            rd(0, 5'd3);
            settle();
            chk("raw_busy", {31'b0, rd_busy[0]}, 32'h1);
            chk("raw_stall", {31'b0, stall}, 32'h1);
            chk("raw_no_fire", {31'b0, iss_fire}, 32'h0);
        end
        step();
        idle();
        iss(5'd10, 1'b0);
        rd(0, 5'd3);
        wb(5'd3, 32'h0000_0033);
        settle();
        chk("raw_wb_stall", {31'b0, stall}, 32'h0);
        chk("raw_wb_fire", {31'b0, iss_fire}, 32'h1);
        chk("raw_wb_busy", {31'b0, rd_busy[0]}, 32'h0);
        chk("raw_wb_data", rd_data[31:0], 32'h0000_0033);
        step();
        idle();
        rd(0, 5'd3);
        rd(1, 5'd10);
        settle();
        chk("raw_after_busy", {31'b0, rd_busy[0]}, 32'h0);
        chk("raw_after_data", rd_data[31:0], 32'h0000_0033);
        chk("stalled_issue_not_counted", {31'b0, rd_busy[1]}, 32'h0);

        // WAW on r7.
        step();
        idle();
        iss(5'd7, 1'b1);
        settle();
        chk("waw_fire1", {31'b0, iss_fire}, 32'h1);
        step();
        idle();
        iss(5'd7, 1'b1);
        settle();
        chk("waw_fire2", {31'b0, iss_fire}, 32'h1);
        step();
        idle();
        rd(0, 5'd7);
        wb(5'd7, 32'h0000_0071);
        settle();
        chk("waw_wb1_busy", {31'b0, rd_busy[0]}, 32'h1);
        chk("waw_wb1_data", rd_data[31:0], 32'h0000_0071);
        step();
        idle();
        rd(0, 5'd7);
        settle();
        chk("waw_pend1_busy", {31'b0, rd_busy[0]}, 32'h1);
        wb(5'd7, 32'h0000_0072);
        settle();
        chk("waw_wb2_busy", {31'b0, rd_busy[0]}, 32'h0);
        chk("waw_wb2_data", rd_data[31:0], 32'h0000_0072);
        step();
        idle();
        rd(0, 5'd7);
        settle();
        chk("waw_done_busy", {31'b0, rd_busy[0]}, 32'h0);
        chk("waw_done_data", rd_data[31:0], 32'h0000_0072);

        // Saturation on r9.
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            iss(5'd9, 1'b1);
            settle();
            chk("sat_fill_fire", {31'b0, iss_fire}, 32'h1);
        end
        step();
        idle();
        iss(5'd9, 1'b1);
        settle();
        chk("sat_full_stall", {31'b0, stall}, 32'h1);
        chk("sat_full_no_fire", {31'b0, iss_fire}, 32'h0);
        step();
        idle();
        iss(5'd9, 1'b1);
        wb(5'd9, 32'h0000_0099);
        settle();
        chk("sat_wb_stall", {31'b0, stall}, 32'h0);
        chk("sat_wb_fire", {31'b0, iss_fire}, 32'h1);
        step();
        idle();
        iss(5'd9, 1'b1);
        settle();
        chk("sat_still_full", {31'b0, stall}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            wb(5'd9, 32'h0000_0090 + 32'(i));
            step();
            idle();
            rd(0, 5'd9);
            settle();
            chk("sat_drain_busy", {31'b0, rd_busy[0]}, (i < 2) ? 32'h1 : 32'h0);
        end

        // Register 0.
        step();
        idle();
        iss(5'd0, 1'b1);
        wb(5'd0, 32'h0000_1234);
        rd(0, 5'd0);
        settle();
        chk("r0_data", rd_data[31:0], 32'h0);
        chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
        chk("r0_stall", {31'b0, stall}, 32'h0);
        chk("r0_fire", {31'b0, iss_fire}, 32'h1);
        step();
        idle();
        rd(1, 5'd0);
        settle();
        chk("r0_after_data", rd_data[63:32], 32'h0);
        chk("r0_after_busy", {31'b0, rd_busy[1]}, 32'h0);

        // Reset mid-operation with r4 two writes pending.
        step();
        idle();
        wb(5'd4, 32'h0000_0044);
        step();
        idle();
        iss(5'd4, 1'b1);
        step();
        idle();
        iss(5'd4, 1'b1);
        step();
        idle();
        rd(0, 5'd4);
        rd(1, 5'd5);
        iss(5'd20, 1'b0);
        settle();
        chk("pre_rst_busy", {31'b0, rd_busy[0]}, 32'h1);
        chk("pre_rst_data", rd_data[31:0], 32'h0000_0044);
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        rst = 1'b0;
        settle();
        chk("mid_rst_busy", {30'b0, rd_busy}, 32'h0);
        chk("mid_rst_data4", rd_data[31:0], 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        chk("mid_rst_fire", {31'b0, iss_fire}, 32'h0);
        step();
        rst = 1'b1;
        step();
        idle();
        rd(0, 5'd4);
        rd(1, 5'd5);
        settle();
        chk("post_rst_busy4", {31'b0, rd_busy[0]}, 32'h0);
        chk("post_rst_data4", rd_data[31:0], 32'h0);
        chk("post_rst_data5", rd_data[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
